spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, single system clock domain. Oversamples SCLK, SS_n and MOSI through synchronizers and edge detectors. Shifts a byte in on MOSI while shifting a parallel byte out on MISO. Serves as the peripheral-side counterpart to the system's SPI master, with back-to-back bytes allowed inside one SS_n frame.

Parameters:
DATA_WIDTH, 8, bits per SPI word; bit counter width is clog2(DATA_WIDTH).
SYNC_STAGES, 2, synchronizer flops on spiClk_i, ss_i_n and mosi_i (minimum 2).

Ports:
sysClk_i  input  1  system clock; every flop in the block is clocked on its rising edge.
reset_i  input  1  synchronous reset, active-low.
spiClk_i  input  1  SPI clock from the master; asynchronous; idles low.
ss_i_n  input  1  slave select, active-low; asynchronous.
mosi_i  input  1  serial data from the master; asynchronous.
miso_o  output  1  serial data to the master; registered.
byte_to_send_i  input  DATA_WIDTH  parallel word to transmit; sampled at frame start and at each word boundary.
byte_received_o  output  DATA_WIDTH  last complete received word; holds its value until the next word completes.
rx_valid_o  output  1  one-cycle pulse; byte_received_o updates in the same cycle.
busy_o  output  1  high while a frame is active.
abort_o  output  1  one-cycle pulse when SS_n rises mid-word.

Behaviour:
- Reset (reset_i=0 at a sysClk_i edge):
  - miso_o=0, byte_received_o=0, rx_valid_o=0, busy_o=0, abort_o=0.
  - State goes to SSIdle; bit counter=0; tx_shift=0; rx_shift=0.
  - All synchronizer and history flops load 0. An SS_n held low through reset release therefore does not start a frame. SS_n must rise and fall again first.
- Sync and edge detection:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Latency from pin to detected edge is SYNC_STAGES+1 cycles.
  - The master must hold each SCLK half-period at least SYNC_STAGES+2 sysClk cycles.
  - MOSI is sampled from its synchronized value, which is aligned to the SCLK synchronized value.
- States: SSIdle and SSActive. busy_o is high exactly when the state is SSActive.
- SSIdle:
  - On SS fall: tx_shift<=byte_to_send_i; miso_o<=byte_to_send_i[MSB]; bitCnt<=0; go to SSActive.
  - SCLK edges are ignored. miso_o is held at 0.
- SSActive, on SCLK rise:
  - rx_shift<={rx_shift[DATA_WIDTH-2:0], mosi_sync}; bitCnt<=bitCnt+1.
  - If bitCnt==DATA_WIDTH-1, the word completes:
    - byte_received_o<={rx_shift[DATA_WIDTH-2:0], mosi_sync}; rx_valid_o=1 for that one cycle.
    - bitCnt<=0 (wraps).
    - tx_shift<=byte_to_send_i; miso_o<=byte_to_send_i[MSB]. This starts the next word in the same frame.
- SSActive, on SCLK fall:
  - If bitCnt!=0: tx_shift<=tx_shift<<1; miso_o<=tx_shift[MSB-1].
  - If bitCnt==0: no shift, so the first bit of a freshly loaded word is preserved.
- SSActive, on SS rise:
  - Go to SSIdle; miso_o<=0; bitCnt<=0.
  - If bitCnt!=0, abort_o=1 for one cycle. The partial word is discarded; byte_received_o and rx_valid_o are unchanged.
  - SS rise with bitCnt==0 is a clean end; no abort.
- Simultaneous events (same sysClk cycle):
  - SS rise beats an SCLK edge; the SCLK edge is dropped.
  - SS fall in SSIdle with an SCLK edge: only the frame start is taken.
  - SCLK rise and fall cannot be detected together.
- Reset mid-frame: the frame is abandoned immediately, with no abort_o pulse and no rx_valid_o.
- byte_to_send_i needs to be stable only in the sampling cycles: the SS fall cycle and the word-complete cycle.

Test Plan:
1. Single word: byte_to_send_i=0xA5, master sends 0x3C with SCLK half-period 4 cycles → miso_o bits 1,0,1,0,0,1,0,1 at successive SCLK rises; rx_valid_o pulses once; byte_received_o=0x3C; busy_o falls after SS rise; abort_o never pulses.
2. Back-to-back words in one frame: master sends 0x81 then 0x7E; byte_to_send_i=0x55, changed to 0xF0 before the 8th rise → two rx_valid_o pulses with byte_received_o 0x81 then 0x7E; MISO carries 0x55 then 0xF0.
3. Abort: SS rises after 3 SCLK rises → abort_o pulses once; byte_received_o keeps its prior value (0x7E); state returns to SSIdle; miso_o=0.
4. Reset: assert reset_i low mid-word (bitCnt=5) while SS is held low → all outputs 0; no frame starts until SS toggles high then low; the next 0xC3 frame is received correctly.
5. Idle noise: toggle SCLK 10 times with SS high → no rx_valid_o, busy_o=0, miso_o=0.
6. Race: SS rise in the same cycle as a synchronized SCLK rise at bitCnt=7 → abort_o=1, no rx_valid_o, byte_received_o unchanged.

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI mode 0 slave (CPOL=0, CPHA=0), MSB first.
// SCLK, SS_n and MOSI are oversampled in the system clock domain through
// synchronizers and edge detectors. Back-to-back words may be exchanged
// inside one SS_n frame.
module spi_slave_sync #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sysClk_i,
   input  logic                  reset_i,
   input  logic                  spiClk_i,
   input  logic                  ss_i_n,
   input  logic                  mosi_i,
   output logic                  miso_o,
   input  logic [DATA_WIDTH-1:0] byte_to_send_i,
   output logic [DATA_WIDTH-1:0] byte_received_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   output logic                  abort_o
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [0:0] {
      SS_IDLE   = 1'b0,
      SS_ACTIVE = 1'b1
   } state_e;

   // synchronizer chains and edge-history flops
   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_hist_q, ss_hist_q;

   // edge detection on the synchronized levels
   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

   // frame state and datapath
   state_e                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-2:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_word_s;
   logic                  miso_q, miso_d;
   logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  abort_q, abort_d;

   // Bring the asynchronous pins into the sysClk domain; all flops clear on reset
   // so an SS_n already low at reset release is not seen as a falling edge.
   always_ff @(posedge sysClk_i) begin
      if (!reset_i) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         ss_hist_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s        = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_hist_q;
   assign sclk_fall_s = ~sclk_s & sclk_hist_q;
   assign ss_rise_s   = ss_s & ~ss_hist_q;
   assign ss_fall_s   = ~ss_s & ss_hist_q;

   // Frame state, shift registers and registered outputs.
   always_ff @(posedge sysClk_i) begin
      if (!reset_i) begin
         state_q    <= SS_IDLE;
         bit_cnt_q  <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         miso_q     <= 1'b0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         miso_q     <= miso_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         abort_q    <= abort_d;
      end
   end

   // Next-state logic: SS edges take priority over SCLK edges in the same cycle.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      miso_d     = miso_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      abort_d    = 1'b0;
      rx_word_s  = {rx_q, mosi_s};

      case (state_q)
         SS_IDLE: begin
            miso_d = 1'b0;
            if (ss_fall_s) begin
               tx_d      = byte_to_send_i;
               miso_d    = byte_to_send_i[DATA_WIDTH-1];
               bit_cnt_d = '0;
               state_d   = SS_ACTIVE;
            end else begin
               bit_cnt_d = '0;
            end
         end
         SS_ACTIVE: begin
            if (ss_rise_s) begin
               // a partial word is dropped; only a mid-word end is an abort
               state_d   = SS_IDLE;
               miso_d    = 1'b0;
               bit_cnt_d = '0;
               abort_d   = (bit_cnt_q != '0);
            end else if (sclk_rise_s) begin
               rx_d = rx_word_s[DATA_WIDTH-2:0];
               if (bit_cnt_q == LAST_BIT) begin
                  rx_byte_d  = rx_word_s;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  tx_d       = byte_to_send_i;
                  miso_d     = byte_to_send_i[DATA_WIDTH-1];
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (sclk_fall_s) begin
               // no shift at bit 0 keeps the MSB of a freshly loaded word on MISO
               if (bit_cnt_q != '0) begin
                  tx_d   = tx_q << 1;
                  miso_d = tx_q[DATA_WIDTH-2];
               end else begin
                  tx_d = tx_q;
               end
            end else begin
               state_d = SS_ACTIVE;
            end
         end
         default: begin
            state_d   = SS_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
         end
      endcase
   end

   assign miso_o          = miso_q;
   assign byte_received_o = rx_byte_q;
   assign rx_valid_o      = rx_valid_q;
   assign abort_o         = abort_q;
   assign busy_o          = (state_q == SS_ACTIVE);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Testbench for spi_slave_sync: directed test-plan scenarios followed by
// random frames, all checked against a word-level reference model.
module tb_spi_slave_sync;

   logic       clk;
   logic       reset_i;
   logic       spiClk_i;
   logic       ss_i_n;
   logic       mosi_i;
   logic       miso_o;
   logic [7:0] byte_to_send_i;
   logic [7:0] byte_received_o;
   logic       rx_valid_o;
   logic       busy_o;
   logic       abort_o;

   int n_assert = 0;
   int n_fail   = 0;

   // word-level reference model: received words and abort count
   logic [7:0] exp_rx[$];
   int         exp_abort = 0;
   logic [7:0] exp_last  = 8'h00;

   // what the DUT actually reported
   logic [7:0] rx_seen[$];
   int         abort_seen = 0;

   spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .sysClk_i        (clk),
      .reset_i         (reset_i),
      .spiClk_i        (spiClk_i),
      .ss_i_n          (ss_i_n),
      .mosi_i          (mosi_i),
      .miso_o          (miso_o),
      .byte_to_send_i  (byte_to_send_i),
      .byte_received_o (byte_received_o),
      .rx_valid_o      (rx_valid_o),
      .busy_o          (busy_o),
      .abort_o         (abort_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // log rx_valid / abort pulses just after each active edge
   always @(posedge clk) begin
      #1;
      if (rx_valid_o) rx_seen.push_back(byte_received_o);
      if (abort_o) abort_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, " rx count"}, 32'(rx_seen.size()), 32'(exp_rx.size()));
      if (rx_seen.size() == exp_rx.size()) begin
         for (int i = 0; i < exp_rx.size(); i++) check({tag, " rx word"}, 32'(rx_seen[i]), 32'(exp_rx[i]));
      end
      check({tag, " abort count"}, 32'(abort_seen), 32'(exp_abort));
      check({tag, " byte_received"}, 32'(byte_received_o), 32'(exp_last));
   endtask

   // one full master word; next_tx is presented after the first rise
   task automatic spi_word(input logic [7:0] mo, input logic [7:0] next_tx, input int h,
                           output logic [7:0] mi);
      for (int i = 7; i >= 0; i--) begin
         mosi_i = mo[i];
         cyc(h);
         mi[i] = miso_o;
         spiClk_i = 1'b1;
         if (i == 7) byte_to_send_i = next_tx;
         cyc(h);
         spiClk_i = 1'b0;
      end
   endtask

   // n SCLK periods, ending with SCLK low
   task automatic spi_bits(input logic [7:0] mo, input int n, input int h);
      for (int i = 0; i < n; i++) begin
         mosi_i = mo[7-i];
         cyc(h);
         spiClk_i = 1'b1;
         cyc(h);
         spiClk_i = 1'b0;
      end
   endtask

   task automatic frame_start(input int h);
      ss_i_n = 1'b0;
      cyc(h);
   endtask

   task automatic frame_end(input int h);
      cyc(h);
      ss_i_n = 1'b1;
      cyc(h + 2);
   endtask

   initial begin
      logic [7:0] mi, mo, nt, etx;
      int h, nw;

      reset_i = 1'b0; spiClk_i = 1'b0; ss_i_n = 1'b1; mosi_i = 1'b0;
      byte_to_send_i = 8'h00;
      cyc(4);
      check("reset miso", 32'(miso_o), 32'h0);
      check("reset byte_received", 32'(byte_received_o), 32'h0);
      check("reset rx_valid", 32'(rx_valid_o), 32'h0);
      check("reset busy", 32'(busy_o), 32'h0);
      check("reset abort", 32'(abort_o), 32'h0);
      reset_i = 1'b1;
      cyc(4);

      // 1: single word
      byte_to_send_i = 8'hA5;
      frame_start(4);
      check("t1 busy in frame", 32'(busy_o), 32'h1);
      check("t1 first miso bit", 32'(miso_o), 32'h1);
      spi_word(8'h3C, 8'h00, 4, mi);
      check("t1 miso word", 32'(mi), 32'hA5);
      exp_rx.push_back(8'h3C); exp_last = 8'h3C;
      frame_end(4);
      check("t1 busy after", 32'(busy_o), 32'h0);
      check("t1 miso idle", 32'(miso_o), 32'h0);
      check_log("t1");

      // 2: back-to-back words
      byte_to_send_i = 8'h55;
      frame_start(5);
      spi_word(8'h81, 8'hF0, 5, mi);
      check("t2 miso word0", 32'(mi), 32'h55);
      check("t2 busy between words", 32'(busy_o), 32'h1);
      spi_word(8'h7E, 8'h00, 5, mi);
      check("t2 miso word1", 32'(mi), 32'hF0);
      exp_rx.push_back(8'h81); exp_rx.push_back(8'h7E); exp_last = 8'h7E;
      frame_end(5);
      check_log("t2");

      // 3: abort after three rises
      byte_to_send_i = 8'hFF;
      frame_start(4);
      spi_bits(8'hE0, 3, 4);
      frame_end(4);
      exp_abort++;
      check("t3 busy", 32'(busy_o), 32'h0);
      check("t3 miso", 32'(miso_o), 32'h0);
      check_log("t3");

      // 6: SS rise together with the 8th SCLK rise
      frame_start(4);
      spi_bits(8'hAA, 7, 4);
      mosi_i = 1'b1;
      cyc(4);
      spiClk_i = 1'b1; ss_i_n = 1'b1;
      cyc(4);
      spiClk_i = 1'b0;
      cyc(6);
      exp_abort++;
      check("t6 busy", 32'(busy_o), 32'h0);
      check_log("t6");

      // 4: reset mid-word with SS held low
      frame_start(4);
      spi_bits(8'hFF, 5, 4);
      reset_i = 1'b0;
      cyc(3);
      check("t4 reset miso", 32'(miso_o), 32'h0);
      check("t4 reset byte_received", 32'(byte_received_o), 32'h0);
      check("t4 reset busy", 32'(busy_o), 32'h0);
      check("t4 reset rx_valid", 32'(rx_valid_o), 32'h0);
      check("t4 reset abort", 32'(abort_o), 32'h0);
      reset_i = 1'b1;
      exp_rx.delete(); rx_seen.delete(); exp_last = 8'h00;
      spi_bits(8'hFF, 8, 4);
      check("t4 no frame after reset", 32'(busy_o), 32'h0);
      check_log("t4 held");
      ss_i_n = 1'b1;
      cyc(6);
      byte_to_send_i = 8'h96;
      frame_start(4);
      spi_word(8'hC3, 8'h00, 4, mi);
      check("t4 miso word", 32'(mi), 32'h96);
      exp_rx.push_back(8'hC3); exp_last = 8'hC3;
      frame_end(4);
      check_log("t4");

      // 5: SCLK noise with SS high
      for (int i = 0; i < 10; i++) begin
         spiClk_i = 1'b1; cyc(4);
         check("t5 miso", 32'(miso_o), 32'h0);
         spiClk_i = 1'b0; cyc(4);
         check("t5 busy", 32'(busy_o), 32'h0);
      end
      check_log("t5");

      // random frames of 1..3 words at random SCLK rates
      for (int f = 0; f < 6; f++) begin
         h   = int'($urandom_range(7, 4));
         nw  = int'($urandom_range(3, 1));
         etx = 8'($urandom);
         byte_to_send_i = etx;
         frame_start(h);
         for (int w = 0; w < nw; w++) begin
            mo = 8'($urandom);
            nt = 8'($urandom);
            spi_word(mo, nt, h, mi);
            check("rand miso word", 32'(mi), 32'(etx));
            exp_rx.push_back(mo); exp_last = mo;
            etx = nt;
         end
         frame_end(h);
         check_log("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // guard against a stalled simulation
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
